// File: rtl/poly_arith_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | poly_arith_pkg : shared coefficient, PE mode and issue-state types   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package poly_arith_pkg;

  localparam int COEFF_W = 16;

  typedef logic [COEFF_W-1:0] coeff_t;

  typedef enum logic [2:0] {
    PE_MODE_NTT  = 3'd0,
    PE_MODE_INTT = 3'd1,
    PE_MODE_CWM  = 3'd2,
    PE_MODE_ADD  = 3'd3,
    PE_MODE_SUB  = 3'd4
  } pe_mode_e;

  typedef enum logic [1:0] {
    PE_ISSUE_STREAM = 2'd0,
    PE_ISSUE_DRAIN  = 2'd1,
    PE_ISSUE_GAP    = 2'd2
  } pe_issue_state_e;

  typedef struct packed {
    coeff_t   u;
    coeff_t   v;
    pe_mode_e mode;
  } pe_result_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with occupancy count, zero when empty  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push = push_i && (count_q != CNT_W'(DEPTH));
  assign w_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (w_push && !w_pop)      count_d = count_q + CNT_W'(1);
    else if (!w_push && w_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pe_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_issue_ctrl : credit-limited issue/drain/mode-switch controller    |
// | for one butterfly PE with an in-order, mode-tagged result FIFO.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pe_issue_ctrl
  import poly_arith_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8,
  parameter int SWITCH_GAP   = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req_valid_i,
  output logic     req_ready_o,
  input  coeff_t   req_a_i,
  input  coeff_t   req_b_i,
  input  coeff_t   req_w_i,
  input  coeff_t   req_tf_i,
  input  pe_mode_e req_mode_i,
  output logic     pe_valid_o,
  output coeff_t   pe_a_o,
  output coeff_t   pe_b_o,
  output coeff_t   pe_w_o,
  output coeff_t   pe_tf_o,
  output pe_mode_e pe_ctrl_o,
  input  logic     pe_valid_i,
  input  coeff_t   pe_u_i,
  input  coeff_t   pe_v_i,
  output logic     res_valid_o,
  input  logic     res_ready_i,
  output coeff_t   res_u_o,
  output coeff_t   res_v_o,
  output pe_mode_e res_mode_o,
  output logic     busy_o,
  output logic     err_o
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int GAP_W = (SWITCH_GAP > 0) ? $clog2(SWITCH_GAP + 1) : 1;

  pe_issue_state_e state_q, state_d;
  pe_mode_e        cur_mode_q, cur_mode_d;
  pe_mode_e        pend_mode_q, pend_mode_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic            pe_valid_q, pe_valid_d;
  coeff_t          pe_a_q, pe_a_d, pe_b_q, pe_b_d;
  coeff_t          pe_w_q, pe_w_d, pe_tf_q, pe_tf_d;
  logic            err_q, err_d;

  logic             w_fifo_valid;
  logic [CNT_W-1:0] w_fifo_count;
  pe_result_t       w_push_data, w_head;
  logic             w_credit_ok, w_ready, w_accept, w_return, w_ghost;

  // FIFO occupancy is registered, so credits freed by a pop appear next cycle.
  assign w_credit_ok = ({1'b0, inflight_q} + {1'b0, w_fifo_count})
                       < (CNT_W + 1)'(MAX_INFLIGHT);
  assign w_ready  = rst_n && (state_q == PE_ISSUE_STREAM)
                    && (req_mode_i == cur_mode_q) && w_credit_ok;
  assign w_accept = req_valid_i && w_ready;
  assign w_return = pe_valid_i && (inflight_q != '0);
  assign w_ghost  = pe_valid_i && (inflight_q == '0);

  assign w_push_data = '{u: pe_u_i, v: pe_v_i, mode: cur_mode_q};

  always_comb begin
    state_d     = state_q;
    cur_mode_d  = cur_mode_q;
    pend_mode_d = pend_mode_q;
    gap_cnt_d   = gap_cnt_q;
    inflight_d  = inflight_q;
    err_d       = err_q | w_ghost;
    pe_valid_d  = w_accept;
    pe_a_d      = w_accept ? req_a_i  : '0;
    pe_b_d      = w_accept ? req_b_i  : '0;
    pe_w_d      = w_accept ? req_w_i  : '0;
    pe_tf_d     = w_accept ? req_tf_i : '0;

    if (w_accept && !w_return)      inflight_d = inflight_q + CNT_W'(1);
    else if (!w_accept && w_return) inflight_d = inflight_q - CNT_W'(1);

    case (state_q)
      PE_ISSUE_STREAM: begin
        if (req_valid_i && (req_mode_i != cur_mode_q)) begin
          state_d     = PE_ISSUE_DRAIN;
          pend_mode_d = req_mode_i;
        end
      end
      PE_ISSUE_DRAIN: begin
        // Queued results keep their own mode tag, so only the PE must be empty.
        if (inflight_q == '0) begin
          cur_mode_d = pend_mode_q;
          gap_cnt_d  = GAP_W'(SWITCH_GAP);
          state_d    = (SWITCH_GAP == 0) ? PE_ISSUE_STREAM : PE_ISSUE_GAP;
        end
      end
      PE_ISSUE_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) state_d = PE_ISSUE_STREAM;
        else                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = PE_ISSUE_STREAM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PE_ISSUE_STREAM;
      cur_mode_q  <= PE_MODE_NTT;
      pend_mode_q <= PE_MODE_NTT;
      inflight_q  <= '0;
      gap_cnt_q   <= '0;
      pe_valid_q  <= 1'b0;
      pe_a_q      <= '0;
      pe_b_q      <= '0;
      pe_w_q      <= '0;
      pe_tf_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_mode_q  <= cur_mode_d;
      pend_mode_q <= pend_mode_d;
      inflight_q  <= inflight_d;
      gap_cnt_q   <= gap_cnt_d;
      pe_valid_q  <= pe_valid_d;
      pe_a_q      <= pe_a_d;
      pe_b_q      <= pe_b_d;
      pe_w_q      <= pe_w_d;
      pe_tf_q     <= pe_tf_d;
      err_q       <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(pe_result_t)),
    .DEPTH (MAX_INFLIGHT)
  ) u_result_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_return),
    .data_i  (w_push_data),
    .pop_i   (res_ready_i),
    .valid_o (w_fifo_valid),
    .data_o  (w_head),
    .count_o (w_fifo_count)
  );

  assign req_ready_o = w_ready;
  assign pe_valid_o  = pe_valid_q;
  assign pe_a_o      = pe_a_q;
  assign pe_b_o      = pe_b_q;
  assign pe_w_o      = pe_w_q;
  assign pe_tf_o     = pe_tf_q;
  assign pe_ctrl_o   = cur_mode_q;
  assign res_valid_o = w_fifo_valid;
  assign res_u_o     = w_head.u;
  assign res_v_o     = w_head.v;
  assign res_mode_o  = w_head.mode;
  assign busy_o      = (inflight_q != '0) || w_fifo_valid || (state_q != PE_ISSUE_STREAM);
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pe_issue_ctrl : bench for pe_issue_ctrl with a latency-3 PE model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pe_issue_ctrl;
  import poly_arith_pkg::*;

  localparam int MAX = 8;
  localparam int GAP = 2;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     rst_n = 1'b0, req_valid_i = 1'b0, pe_valid_i = 1'b0, res_ready_i = 1'b0;
  coeff_t   req_a_i = '0, req_b_i = '0, req_w_i = '0, req_tf_i = '0, pe_u_i = '0, pe_v_i = '0;
  pe_mode_e req_mode_i = PE_MODE_NTT;
  logic     req_ready_o, pe_valid_o, res_valid_o, busy_o, err_o;
  coeff_t   pe_a_o, pe_b_o, pe_w_o, pe_tf_o, res_u_o, res_v_o;
  pe_mode_e pe_ctrl_o, res_mode_o;

  pe_issue_ctrl #(.MAX_INFLIGHT(MAX), .SWITCH_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_w_i(req_w_i), .req_tf_i(req_tf_i),
    .req_mode_i(req_mode_i), .pe_valid_o(pe_valid_o), .pe_a_o(pe_a_o), .pe_b_o(pe_b_o),
    .pe_w_o(pe_w_o), .pe_tf_o(pe_tf_o), .pe_ctrl_o(pe_ctrl_o), .pe_valid_i(pe_valid_i),
    .pe_u_i(pe_u_i), .pe_v_i(pe_v_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_u_o(res_u_o), .res_v_o(res_v_o), .res_mode_o(res_mode_o), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct { coeff_t u; coeff_t v; pe_mode_e m; } res_t;
  typedef struct { int due; coeff_t u; coeff_t v; } pe_item_t;

  // staged stimulus, applied at the next falling edge
  logic     s_rst_n = 1'b0, s_valid = 1'b0, s_res_ready = 1'b0;
  coeff_t   s_a = '0, s_b = '0, s_w = '0, s_tf = '0;
  pe_mode_e s_mode = PE_MODE_NTT;
  int       ghost_req = 0;

  // behavioural model: phase 0 = streaming, 1 = draining, 2 = gap
  res_t     m_fifo[$];
  res_t     sb[$];
  pe_item_t pe_q[$];
  int       m_inflight, m_phase, m_gap;
  pe_mode_e m_mode, m_pend;
  logic     m_err, m_pv;
  coeff_t   m_pa, m_pb, m_pw, m_ptf;

  int checks = 0, failures = 0, cyc = 0, acc_cnt = 0, n_popped = 0;
  int pv_run = 0, pv_max = 0, pv_total = 0;
  logic last_acc = 1'b0;
  coeff_t first_u = '0, first_v = '0;
  logic d_ready, d_pv, d_err, d_busy, d_res_valid;
  pe_mode_e d_ctrl;

  function automatic res_t golden(coeff_t a, coeff_t b, coeff_t w, coeff_t tf, pe_mode_e m);
    res_t r;
    coeff_t bt;
    bt  = coeff_t'(b * tf);
    r.u = a + bt + {13'd0, m};
    r.v = a - bt + w;
    r.m = m;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_inflight = 0; m_phase = 0; m_gap = 0;
    m_mode = PE_MODE_NTT; m_pend = PE_MODE_NTT;
    m_err = 1'b0; m_pv = 1'b0;
    m_pa = '0; m_pb = '0; m_pw = '0; m_ptf = '0;
    m_fifo.delete(); sb.delete(); pe_q.delete();
  endtask

  // One clock cycle: drive inputs, compare every output, advance the model.
  task automatic step();
    logic exp_ready, acc, ret, ghost, pop;
    res_t r;
    pe_item_t it;
    @(negedge clk);
    cyc++;
    rst_n = s_rst_n; req_valid_i = s_valid; req_mode_i = s_mode; res_ready_i = s_res_ready;
    req_a_i = s_a; req_b_i = s_b; req_w_i = s_w; req_tf_i = s_tf;
    pe_valid_i = 1'b0; pe_u_i = '0; pe_v_i = '0;
    if (s_rst_n) begin
      if (pe_q.size() > 0 && pe_q[0].due == cyc) begin
        pe_valid_i = 1'b1; pe_u_i = pe_q[0].u; pe_v_i = pe_q[0].v;
        void'(pe_q.pop_front());
      end else if (ghost_req > 0 && pe_q.size() == 0) begin
        pe_valid_i = 1'b1; pe_u_i = coeff_t'($urandom); pe_v_i = coeff_t'($urandom);
        ghost_req--;
      end
    end
    if (!s_rst_n) model_reset();
    #1;
    d_ready = req_ready_o; d_pv = pe_valid_o; d_err = err_o; d_busy = busy_o;
    d_res_valid = res_valid_o; d_ctrl = pe_ctrl_o;

    exp_ready = s_rst_n && (m_phase == 0) && (s_mode == m_mode) && (m_inflight + m_fifo.size() < MAX);
    chk("req_ready", req_ready_o, exp_ready);
    chk("pe_valid", pe_valid_o, m_pv);
    chk("pe_a", pe_a_o, m_pa);
    chk("pe_b", pe_b_o, m_pb);
    chk("pe_w", pe_w_o, m_pw);
    chk("pe_tf", pe_tf_o, m_ptf);
    chk("pe_ctrl", pe_ctrl_o, m_mode);
    chk("res_valid", res_valid_o, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      chk("res_u", res_u_o, m_fifo[0].u);
      chk("res_v", res_v_o, m_fifo[0].v);
      chk("res_mode", res_mode_o, m_fifo[0].m);
    end
    chk("busy", busy_o, (m_inflight != 0) || (m_fifo.size() > 0) || (m_phase != 0));
    chk("err", err_o, m_err);

    if (pe_valid_o === 1'b1) begin
      pv_total++; pv_run++;
      if (pv_run > pv_max) pv_max = pv_run;
    end else pv_run = 0;
    if (s_rst_n && pe_valid_o === 1'b1) begin
      r = golden(pe_a_o, pe_b_o, pe_w_o, pe_tf_o, pe_ctrl_o);
      it.due = cyc + LAT; it.u = r.u; it.v = r.v;
      pe_q.push_back(it);
    end
    if (!s_rst_n) begin
      last_acc = 1'b0;
      return;
    end

    acc   = s_valid && exp_ready;
    ret   = pe_valid_i && (m_inflight > 0);
    ghost = pe_valid_i && (m_inflight == 0);
    pop   = s_res_ready && (m_fifo.size() > 0);
    if (pop) begin
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("pop_u_golden", res_u_o, r.u);
        chk("pop_v_golden", res_v_o, r.v);
        chk("pop_mode_golden", res_mode_o, r.m);
      end else chk("pop_without_request", 1, 0);
      if (n_popped == 0) begin first_u = res_u_o; first_v = res_v_o; end
      n_popped++;
      void'(m_fifo.pop_front());
    end
    if (ret) begin
      r.u = pe_u_i; r.v = pe_v_i; r.m = m_mode;
      m_fifo.push_back(r);
    end
    if (ghost) m_err = 1'b1;
    if (acc) begin
      sb.push_back(golden(s_a, s_b, s_w, s_tf, s_mode));
      acc_cnt++;
    end
    m_pv = acc;
    m_pa = acc ? s_a : '0; m_pb = acc ? s_b : '0; m_pw = acc ? s_w : '0; m_ptf = acc ? s_tf : '0;
    case (m_phase)
      0: if (s_valid && s_mode != m_mode) begin m_phase = 1; m_pend = s_mode; end
      1: if (m_inflight == 0) begin
           m_mode = m_pend;
           if (GAP == 0) m_phase = 0;
           else begin m_phase = 2; m_gap = GAP; end
         end
      default: if (m_gap <= 1) m_phase = 0; else m_gap--;
    endcase
    m_inflight = m_inflight + int'(acc) - int'(ret);
    last_acc = acc;
  endtask

  task automatic send(input coeff_t a, input coeff_t b, input coeff_t w, input coeff_t tf,
                      input pe_mode_e m);
    int n;
    s_valid = 1'b1; s_a = a; s_b = b; s_w = w; s_tf = tf; s_mode = m;
    n = 0;
    do begin step(); n++; end while (!last_acc && n < 200);
    if (!last_acc) chk("send_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_gap, n, sent, guard, base_pop;
    model_reset();

    // reset state
    s_rst_n = 1'b0; s_res_ready = 1'b1;
    repeat (3) step();
    chk("rst_ready", d_ready, 0);
    chk("rst_pe_valid", d_pv, 0);
    chk("rst_ctrl", d_ctrl, PE_MODE_NTT);
    chk("rst_busy", d_busy, 0);
    chk("rst_err", d_err, 0);
    chk("rst_res_valid", d_res_valid, 0);
    s_rst_n = 1'b1;
    step();

    // six back-to-back NTT issues
    pv_max = 0; pv_total = 0;
    for (int i = 0; i < 6; i++) send(coeff_t'(10 + i), 16'd2, 16'd3, 16'd5, PE_MODE_NTT);
    repeat (20) step();
    chk("t1_pv_run", pv_max, 6);
    chk("t1_pv_total", pv_total, 6);
    chk("t1_popped", n_popped, 6);
    chk("t1_first_u", first_u, 16'd20);
    chk("t1_first_v", first_v, 16'd3);

    // NTT x3 then INTT: count idle cycles with the new mode applied
    for (int i = 0; i < 3; i++) send(coeff_t'(100 + i), 16'd7, 16'd1, 16'd9, PE_MODE_NTT);
    s_valid = 1'b1; s_mode = PE_MODE_INTT; s_a = 16'd55; s_b = 16'd4; s_w = 16'd6; s_tf = 16'd8;
    n_gap = 0; n = 0;
    do begin
      step(); n++;
      if (!last_acc && d_ctrl == PE_MODE_INTT && !d_ready) n_gap++;
    end while (!last_acc && n < 100);
    s_valid = 1'b0;
    chk("t2_accepted", last_acc, 1);
    chk("t2_gap_cycles", n_gap, GAP);
    step();
    chk("t2_first_intt_valid", d_pv, 1);
    chk("t2_first_intt_ctrl", d_ctrl, PE_MODE_INTT);
    repeat (15) step();

    // credit limit with the consumer stalled
    s_res_ready = 1'b0; acc_cnt = 0;
    s_valid = 1'b1; s_mode = PE_MODE_CWM;
    for (int i = 0; i < 60; i++) begin
      step();
      if (last_acc) begin s_a = coeff_t'($urandom); s_b = coeff_t'($urandom); end
    end
    chk("t3_accepted", acc_cnt, MAX);
    chk("t3_ready_low", d_ready, 0);
    s_res_ready = 1'b1;
    step();
    chk("t3_no_bypass", last_acc, 0);
    s_res_ready = 1'b0;
    step();
    chk("t3_one_more", last_acc, 1);
    repeat (20) step();
    chk("t3_total", acc_cnt, MAX + 1);
    s_valid = 1'b0; s_res_ready = 1'b1;
    repeat (30) step();

    // ghost pulse with nothing in flight
    ghost_req = 1;
    repeat (2) step();
    chk("t4_err_set", d_err, 1);
    chk("t4_fifo_empty", d_res_valid, 0);
    repeat (10) step();
    chk("t4_err_sticky", d_err, 1);

    // reset with requests in flight, then late PE pulses
    for (int i = 0; i < 4; i++) send(coeff_t'(i), 16'd3, 16'd2, 16'd1, PE_MODE_CWM);
    chk("t5_busy_before", d_busy, 1);
    s_rst_n = 1'b0;
    step();
    chk("t5_rst_pe_valid", d_pv, 0);
    chk("t5_rst_ctrl", d_ctrl, PE_MODE_NTT);
    chk("t5_rst_err", d_err, 0);
    chk("t5_rst_ready", d_ready, 0);
    chk("t5_rst_busy", d_busy, 0);
    chk("t5_rst_res_valid", d_res_valid, 0);
    step();
    s_rst_n = 1'b1;
    step();
    ghost_req = 2;
    repeat (6) step();
    chk("t5_err_late", d_err, 1);

    // randomized mix of all modes
    s_rst_n = 1'b0;
    repeat (2) step();
    s_rst_n = 1'b1;
    step();
    base_pop = n_popped; sent = 0; guard = 0;
    s_mode = pe_mode_e'($urandom_range(0, 4));
    s_a = coeff_t'($urandom); s_b = coeff_t'($urandom); s_w = coeff_t'($urandom); s_tf = coeff_t'($urandom);
    while ((sent < 500 || sb.size() > 0 || m_inflight > 0) && guard < 20000) begin
      s_valid     = (sent < 500) && ($urandom_range(0, 9) < 8);
      s_res_ready = ($urandom_range(0, 3) != 0);
      step();
      guard++;
      if (last_acc) begin
        sent++;
        s_a = coeff_t'($urandom); s_b = coeff_t'($urandom);
        s_w = coeff_t'($urandom); s_tf = coeff_t'($urandom);
        if ($urandom_range(0, 5) == 0) s_mode = pe_mode_e'($urandom_range(0, 4));
      end
    end
    s_valid = 1'b0;
    chk("t6_within_budget", guard < 20000, 1);
    chk("t6_sent", sent, 500);
    chk("t6_popped", n_popped - base_pop, 500);
    chk("t6_err_clear", d_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
